// File: rtl/display_bcd_driver.sv
// Sequential double-dabble converter from an unsigned binary display word to packed BCD,
// with registered active-low 7-segment outputs, leading-zero blanking and an overflow dash display.
module display_bcd_driver #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIGITS   = 8,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       count;
  logic [WIDTH-1:0]    bin_sr;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic                ovf_sticky;
  logic                last_iter;
  logic [7*DIGITS-1:0] seg_nxt;
  logic                seen_nz;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = 7'b1111111;
    endcase
  endfunction

  assign last_iter = (count == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adj = scratch;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    seg_nxt = '1;
    seen_nz = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*(DIGITS-1-i) +: 4] != 4'd0) seen_nz = 1'b1;
      if (ovf_sticky)
        seg_nxt[7*(DIGITS-1-i) +: 7] = 7'b0111111;
      else if (!(BLANK_LZ && !seen_nz && (i != DIGITS - 1)))
        seg_nxt[7*(DIGITS-1-i) +: 7] = seg_encode(scratch[4*(DIGITS-1-i) +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      bin_sr     <= '0;
      scratch    <= '0;
      ovf_sticky <= 1'b0;
      bcd        <= '0;
      seg        <= '1;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr     <= in_bin;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            count      <= '0;
          end
        end
        SHIFT: begin
          // A 1 leaving the top digit means the value needs more than DIGITS digits.
          {scratch, bin_sr} <= {adj[4*DIGITS-2:0], bin_sr, 1'b0};
          if (adj[4*DIGITS-1]) ovf_sticky <= 1'b1;
          count <= count + CW'(1);
        end
        DONE: begin
          bcd       <= scratch;
          ovf       <= ovf_sticky;
          seg       <= seg_nxt;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_bcd_driver.sv
// Self-checking bench for display_bcd_driver: directed scenarios plus random values
// compared against a decimal-arithmetic reference model.
module tb_display_bcd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_bin;
  logic        out_valid;
  logic        busy;
  logic [31:0] bcd;
  logic [55:0] seg;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  display_bcd_driver #(.WIDTH(32), .DIGITS(8), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .busy(busy), .bcd(bcd), .seg(seg), .ovf(ovf)
  );

  function automatic logic model_ovf(input logic [31:0] v);
    return (64'(v) >= 64'd100000000);
  endfunction

  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    logic [31:0] r;
    longint unsigned t;
    t = 64'(v) % 64'd100000000;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [55:0] model_seg(input logic [31:0] v);
    logic [55:0] r;
    longint unsigned p;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      if (model_ovf(v))                r[7*k +: 7] = 7'b0111111;
      else if (k > 0 && 64'(v) < p)    r[7*k +: 7] = 7'b1111111;
      else                             r[7*k +: 7] = seg_tab[int'((64'(v) / p) % 10)];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 00000000", bcd); end
    checks++; if (seg !== '1) begin errors++; $display("FAIL reset_seg: got %h expected %h", seg, 56'hFFFFFFFFFFFFFF); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready: got ready=%b busy=%b expected 1/0", in_ready, busy); end
  endtask

  task automatic test_convert(input logic [31:0] v, input string name);
    int cyc;
    bit seen;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b expected 1", name, in_ready); end
    in_valid = 1'b1; in_bin = v;
    @(posedge clk);
    #1 in_valid = 1'b0; in_bin = $urandom;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept: got %b expected 1", name, busy); end
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || cyc != 33) begin errors++; $display("FAIL %s latency: got %0d (seen=%b) expected 33", name, cyc, seen); end
    checks++; if (bcd !== model_bcd(v)) begin errors++; $display("FAIL %s bcd: got %h expected %h", name, bcd, model_bcd(v)); end
    checks++; if (seg !== model_seg(v)) begin errors++; $display("FAIL %s seg: got %h expected %h", name, seg, model_seg(v)); end
    checks++; if (ovf !== model_ovf(v)) begin errors++; $display("FAIL %s ovf: got %b expected %b", name, ovf, model_ovf(v)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_at_done: got %b expected 1", name, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s pulse_width: got %b expected 0", name, out_valid); end
    checks++; if (bcd !== model_bcd(v)) begin errors++; $display("FAIL %s bcd_hold: got %h expected %h", name, bcd, model_bcd(v)); end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; in_bin = 32'd42;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_bin = 32'd7;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 5; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || cyc != 33) begin errors++; $display("FAIL busy_latency: got %0d (seen=%b) expected 33", cyc, seen); end
    checks++; if (bcd !== 32'h42) begin errors++; $display("FAIL busy_bcd: got %h expected 00000042", bcd); end
    test_convert(32'd7, "represent7");
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    in_valid = 1'b1; in_bin = 32'hFFFFFFFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bcd !== 32'h0 || ovf !== 1'b0) begin errors++; $display("FAIL midrst_bcd_ovf: got %h/%b expected 00000000/0", bcd, ovf); end
    checks++; if (seg !== '1) begin errors++; $display("FAIL midrst_seg: got %h expected all ones", seg); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int cyc, pulses;
    int t [2];
    logic [31:0] b [2];
    @(negedge clk);
    in_valid = 1'b1; in_bin = 32'd5;
    @(posedge clk);
    #1 in_bin = 32'd6;
    cyc = 0; pulses = 0;
    t[0] = -1; t[1] = -1; b[0] = '0; b[1] = '0;
    while (pulses < 2 && cyc < 150) begin
      @(posedge clk); #1;
      cyc++;
      if (pulses == 1 && cyc == t[0] + 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        t[pulses] = cyc; b[pulses] = bcd; pulses++;
      end
    end
    in_valid = 1'b0;
    checks++; if (pulses != 2 || t[1] - t[0] != 34) begin errors++; $display("FAIL b2b_spacing: got %0d pulses at %0d,%0d expected 2 pulses 34 apart", pulses, t[0], t[1]); end
    checks++; if (b[0] !== 32'h5) begin errors++; $display("FAIL b2b_first: got %h expected 00000005", b[0]); end
    checks++; if (b[1] !== 32'h6) begin errors++; $display("FAIL b2b_second: got %h expected 00000006", b[1]); end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = $urandom_range(0, 999);
        default: v = 32'd99999997 + $urandom_range(0, 6);
      endcase
      test_convert(v, "random");
    end
  endtask

  initial begin
    test_reset();
    test_convert(32'd0, "zero");
    test_convert(32'd12345, "v12345");
    test_convert(32'd99999999, "max8");
    test_convert(32'd100000000, "ovf_min");
    test_convert(32'hFFFFFFFF, "all_ones");
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
